// File: rtl/ll_fifo_pkg.sv
// Shared definitions for the linked-list FIFO and its drain stage.
package ll_fifo_pkg;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int LL_WIDTH_DEF     = 8;
   localparam int LL_NUM_FIFOS_DEF = 2;
   localparam int LL_SEL_WIDTH_DEF = sel_width(LL_NUM_FIFOS_DEF);

   typedef struct packed {
      logic [LL_SEL_WIDTH_DEF-1:0] sel;
      logic [LL_WIDTH_DEF-1:0]     data;
   } ll_entry_t;

endpackage

// File: rtl/ll_fifo_drain_arbiter_if.sv
// Pop side toward linked_list_fifo plus the tagged valid/ready output stream.
interface ll_fifo_drain_arbiter_if #(
   parameter int WIDTH     = 8,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = ll_fifo_pkg::sel_width(NUM_FIFOS)
);
   logic [NUM_FIFOS-1:0] fifo_empty;
   logic [WIDTH-1:0]     fifo_data;
   logic                 pop;
   logic [SEL_WIDTH-1:0] pop_sel;
   logic [NUM_FIFOS-1:0] q_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SEL_WIDTH-1:0] out_sel;

   modport master (
      input  fifo_empty, fifo_data, q_en, out_ready,
      output pop, pop_sel, out_valid, out_data, out_sel
   );

   modport slave (
      output fifo_empty, fifo_data, q_en, out_ready,
      input  pop, pop_sel, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/ll_fifo_drain_arbiter_drain_out_buf.sv
// Two-entry registered output buffer; head is always a register, never a bypass.
module drain_out_buf #(
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [1:0]    cnt_o,
   output logic [DW-1:0] head_o
);
   logic [DW-1:0] mem_q [2];
   logic          rd_ptr_q;
   logic [1:0]    cnt_q, cnt_d;
   logic          do_push, do_pop, wr_idx;

   assign do_push = push_i && (cnt_q != 2'd2);
   assign do_pop  = pop_i && (cnt_q != 2'd0);
   // Tail slot is the head slot when empty, the other slot when one entry is held.
   assign wr_idx  = rd_ptr_q ^ (cnt_q == 2'd1);
   assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) mem_q[wr_idx] <= push_data_i;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign head_o = mem_q[rd_ptr_q];
endmodule

// File: rtl/ll_fifo_drain_arbiter.sv
// Round-robin drain of linked_list_fifo queues onto one tagged valid/ready stream.
module ll_fifo_drain_arbiter
   import ll_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = sel_width(NUM_FIFOS)
) (
   input logic                     clk,
   input logic                     rst,
   ll_fifo_drain_arbiter_if.master bus
);
   localparam int EW = WIDTH + SEL_WIDTH;

   logic [NUM_FIFOS-1:0] eligible;
   logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d, grant;
   logic                 pop;
   logic [1:0]           cnt;
   logic [EW-1:0]        head;

   // Scan downward so the candidate closest to start wins; wraps at NUM_FIFOS.
   function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [NUM_FIFOS-1:0] elig,
                                                    input logic [SEL_WIDTH-1:0] start);
      logic [SEL_WIDTH-1:0] pick;
      int                   idx;
      pick = start;
      for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
         if (elig[idx]) pick = SEL_WIDTH'(idx);
      end
      return pick;
   endfunction

   assign eligible = ~bus.fifo_empty & bus.q_en;
   assign grant    = rr_pick(eligible, rr_ptr_q);
   // Gating on a full buffer keeps out_ready off the pop path entirely.
   assign pop      = rst && (|eligible) && (cnt != 2'd2);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (pop) rr_ptr_d = (int'(grant) == NUM_FIFOS - 1) ? '0 : grant + SEL_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_ptr_q <= '0;
      else      rr_ptr_q <= rr_ptr_d;
   end

   drain_out_buf #(.DW(EW)) u_out_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (pop),
      .push_data_i ({grant, bus.fifo_data}),
      .pop_i       (bus.out_ready),
      .cnt_o       (cnt),
      .head_o      (head)
   );

   assign bus.pop       = pop;
   assign bus.pop_sel   = pop ? grant : rr_ptr_q;
   assign bus.out_valid = (cnt != 2'd0);
   assign bus.out_data  = head[WIDTH-1:0];
   assign bus.out_sel   = head[EW-1:WIDTH];
endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// Directed and table-driven bench for ll_fifo_drain_arbiter (2- and 3-queue builds).
module tb_ll_fifo_drain_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ll_fifo_drain_arbiter_if #(.WIDTH(8), .NUM_FIFOS(2)) b2 ();
   ll_fifo_drain_arbiter_if #(.WIDTH(8), .NUM_FIFOS(3)) b3 ();

   ll_fifo_drain_arbiter #(.WIDTH(8), .NUM_FIFOS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   ll_fifo_drain_arbiter #(.WIDTH(8), .NUM_FIFOS(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

   typedef struct {
      logic [2:0] empty;
      logic [2:0] en;
      logic [7:0] data;
      logic       pop;
      logic [1:0] sel;
      logic       valid;
      logic [1:0] osel;
      logic [7:0] odata;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   // Source queues for dut2: either a small queue model or directly driven flags.
   logic       model_mode = 1'b0;
   logic [1:0] drv_empty  = 2'b00;
   logic [7:0] drv_data   = 8'h00;
   logic [7:0] mem [2][8];
   int         hd [2];
   int         tl [2];

   always_comb begin
      b2.fifo_empty = '0;
      b2.fifo_data  = '0;
      if (model_mode) begin
         for (int i = 0; i < 2; i++) b2.fifo_empty[i] = (hd[i] == tl[i]);
         b2.fifo_data = mem[b2.pop_sel][hd[b2.pop_sel] & 7];
      end else begin
         b2.fifo_empty = drv_empty;
         b2.fifo_data  = drv_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      logic p, s;
      p = b2.pop;
      s = b2.pop_sel;
      @(posedge clk);
      #1;
      if (model_mode && p) hd[s] = hd[s] + 1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
   endtask

   task automatic load(input int q, input logic [7:0] w);
      mem[q][tl[q]] = w;
      tl[q] = tl[q] + 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv2 [10];
      vec_t tv3 [6];
      int   got;
      logic [1:0] elig;

      tv2[0] = '{3'b011, 3'b011, 8'h10, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00};
      tv2[1] = '{3'b010, 3'b011, 8'h11, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00};
      tv2[2] = '{3'b011, 3'b011, 8'h12, 1'b0, 2'd1, 1'b1, 2'd0, 8'h11};
      tv2[3] = '{3'b000, 3'b011, 8'h13, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00};
      tv2[4] = '{3'b000, 3'b010, 8'h14, 1'b1, 2'd1, 1'b1, 2'd1, 8'h13};
      tv2[5] = '{3'b000, 3'b001, 8'h15, 1'b1, 2'd0, 1'b1, 2'd1, 8'h14};
      tv2[6] = '{3'b001, 3'b011, 8'h16, 1'b1, 2'd1, 1'b1, 2'd0, 8'h15};
      tv2[7] = '{3'b000, 3'b000, 8'h17, 1'b0, 2'd0, 1'b1, 2'd1, 8'h16};
      tv2[8] = '{3'b010, 3'b010, 8'h18, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00};
      tv2[9] = '{3'b001, 3'b010, 8'h19, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00};

      tv3[0] = '{3'b101, 3'b111, 8'h30, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00};
      tv3[1] = '{3'b011, 3'b111, 8'h31, 1'b1, 2'd2, 1'b1, 2'd1, 8'h30};
      tv3[2] = '{3'b111, 3'b111, 8'h32, 1'b0, 2'd0, 1'b1, 2'd2, 8'h31};
      tv3[3] = '{3'b101, 3'b111, 8'h33, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00};
      tv3[4] = '{3'b100, 3'b111, 8'h34, 1'b1, 2'd0, 1'b1, 2'd1, 8'h33};
      tv3[5] = '{3'b111, 3'b111, 8'h35, 1'b0, 2'd1, 1'b1, 2'd0, 8'h34};

      clear_model();
      b2.q_en       = 2'b11;
      b2.out_ready  = 1'b1;
      b3.fifo_empty = 3'b111;
      b3.fifo_data  = 8'h00;
      b3.q_en       = 3'b111;
      b3.out_ready  = 1'b1;

      // Reset state with both queues non-empty
      #12;
      check("rst pop", b2.pop, 1'b0);
      check("rst out_valid", b2.out_valid, 1'b0);
      check("rst out_data", b2.out_data, 8'h00);
      check("rst out_sel", b2.out_sel, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drv_empty = 2'b11;

      // Table-driven grant / output checks, 2 queues
      for (int i = 0; i < 10; i++) begin
         drv_empty = tv2[i].empty[1:0];
         b2.q_en   = tv2[i].en[1:0];
         drv_data  = tv2[i].data;
         #2;
         check($sformatf("tbl2[%0d] pop", i), b2.pop, tv2[i].pop);
         check($sformatf("tbl2[%0d] pop_sel", i), b2.pop_sel, tv2[i].sel);
         check($sformatf("tbl2[%0d] out_valid", i), b2.out_valid, tv2[i].valid);
         if (tv2[i].valid) begin
            check($sformatf("tbl2[%0d] out_sel", i), b2.out_sel, tv2[i].osel);
            check($sformatf("tbl2[%0d] out_data", i), b2.out_data, tv2[i].odata);
         end
         tick();
      end

      // Round-robin over two 3-word queues
      drv_empty = 2'b11;
      do_reset();
      clear_model();
      for (int k = 0; k < 3; k++) begin
         load(0, 8'hA0 + 8'(k));
         load(1, 8'hB0 + 8'(k));
      end
      b2.q_en = 2'b11;
      b2.out_ready = 1'b1;
      model_mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #2;
         check($sformatf("rr[%0d] pop", k), b2.pop, 1'b1);
         check($sformatf("rr[%0d] pop_sel", k), b2.pop_sel, 32'(k % 2));
         if (k > 0) begin
            check($sformatf("rr[%0d] out_valid", k), b2.out_valid, 1'b1);
            check($sformatf("rr[%0d] out_sel", k), b2.out_sel, 32'((k - 1) % 2));
            check($sformatf("rr[%0d] out_data", k), b2.out_data,
                  ((k - 1) % 2 == 0) ? 32'h A0 + 32'((k - 1) / 2) : 32'h B0 + 32'((k - 1) / 2));
         end
         tick();
      end
      #2;
      check("rr last pop", b2.pop, 1'b0);
      check("rr last out_sel", b2.out_sel, 1'b1);
      check("rr last out_data", b2.out_data, 8'hB2);
      tick();
      #2;
      check("rr drained out_valid", b2.out_valid, 1'b0);
      tick();

      // Backpressure: 4 words in queue 0, downstream stalled
      model_mode = 1'b0;
      do_reset();
      clear_model();
      for (int k = 0; k < 4; k++) load(0, 8'hC0 + 8'(k));
      b2.out_ready = 1'b0;
      model_mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #2;
         check($sformatf("bp[%0d] pop", k), b2.pop, (k < 2) ? 1'b1 : 1'b0);
         if (k >= 1) check($sformatf("bp[%0d] out_data", k), b2.out_data, 8'hC0);
         tick();
      end
      check("bp popped", hd[0], 2);
      b2.out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         #2;
         if (b2.out_valid) begin
            check($sformatf("bp word%0d", got), b2.out_data, 8'hC0 + 8'(got));
            got++;
         end
         tick();
      end
      check("bp delivered", got, 4);

      // Random empty/enable/ready: never pop an ineligible queue
      model_mode = 1'b0;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         drv_empty    = 2'($urandom);
         b2.q_en      = 2'($urandom);
         b2.out_ready = 1'($urandom);
         drv_data     = 8'($urandom);
         #2;
         elig = ~b2.fifo_empty & b2.q_en;
         if (b2.pop)
            check("rnd pop eligible", {b2.fifo_empty[b2.pop_sel], b2.q_en[b2.pop_sel]}, 2'b01);
         else if (elig != 2'b00 && !b2.out_valid)
            check("rnd pop missing", b2.pop, 1'b1);
         if (elig == 2'b00) check("rnd pop idle", b2.pop, 1'b0);
         tick();
      end

      // Non-power-of-2 wrap, 3 queues
      drv_empty = 2'b11;
      b2.out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         b3.fifo_empty = tv3[i].empty;
         b3.q_en       = tv3[i].en;
         b3.fifo_data  = tv3[i].data;
         #2;
         check($sformatf("tbl3[%0d] pop", i), b3.pop, tv3[i].pop);
         check($sformatf("tbl3[%0d] pop_sel", i), b3.pop_sel, tv3[i].sel);
         check($sformatf("tbl3[%0d] out_valid", i), b3.out_valid, tv3[i].valid);
         if (tv3[i].valid) begin
            check($sformatf("tbl3[%0d] out_sel", i), b3.out_sel, tv3[i].osel);
            check($sformatf("tbl3[%0d] out_data", i), b3.out_data, tv3[i].odata);
         end
         tick();
      end
      b3.fifo_empty = 3'b111;

      // Reset while full with a pop pending
      do_reset();
      clear_model();
      for (int k = 0; k < 4; k++) load(0, 8'hD0 + 8'(k));
      b2.q_en = 2'b11;
      b2.out_ready = 1'b0;
      model_mode = 1'b1;
      tick();
      tick();
      #2;
      check("mid full out_valid", b2.out_valid, 1'b1);
      check("mid full pop gated", b2.pop, 1'b0);
      rst = 1'b0;
      #1;
      check("mid async out_valid", b2.out_valid, 1'b0);
      check("mid async out_data", b2.out_data, 8'h00);
      check("mid async pop", b2.pop, 1'b0);
      @(posedge clk);
      #1;
      model_mode = 1'b0;
      drv_empty = 2'b11;
      rst = 1'b1;
      #2;
      check("mid rr_ptr after reset", b2.pop_sel, 1'b0);
      check("mid out_valid after reset", b2.out_valid, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
